// File: rtl/led_ctrl_term.sv
// Multi-channel LED controller on its own di_* terminal: per-channel off/on/blink/PWM.
// Optional LED_BUTTON_OVERRIDE_EN adds CTRL bit2, letting the synced button force all LEDs on.

module led_ctrl_chan (
   input  logic [1:0] mode,
   input  logic [2:0] rate,
   input  logic [7:0] duty,
   input  logic [7:0] div_top,
   input  logic [7:0] pwm_cnt,
   output logic       state
);
   always_comb begin
      state = 1'b0;
      unique case (mode)
         2'd0: state = 1'b0;
         2'd1: state = 1'b1;
         // rate 0 taps the prescaler MSB; each step taps one bit lower
         2'd2: state = div_top[3'd7 - rate];
         2'd3: state = (pwm_cnt < duty);
      endcase
   end
endmodule

module led_ctrl_term #(
   parameter int          NUM_LEDS  = 4,
   parameter int          DIV_W     = 23,
   parameter logic [15:0] TERM_ADDR = 16'h0010
) (
   input  logic                ifclk,
   input  logic                resetb,
   input  logic [15:0]         di_term_addr,
   input  logic [31:0]         di_reg_addr,
   input  logic                di_write,
   input  logic [15:0]         di_reg_datai,
   input  logic                di_read,
   output logic [15:0]         di_reg_datao,
   output logic                di_read_rdy,
   output logic                di_write_rdy,
   output logic [15:0]         di_transfer_status,
   input  logic                button,
   output logic [NUM_LEDS-1:0] led_b
);
   localparam logic [15:0] CFG_MASK = 16'hFF1F;

   logic                               sel;
   logic [2:0]                         ctrl_q, ctrl_d;
   logic [NUM_LEDS-1:0][15:0]          cfg_q, cfg_d;
   logic [DIV_W-1:0]                   div_q, div_d;
   logic [7:0]                         pwm_q, pwm_d;
   logic                               btn_meta_q, btn_sync_q;
   logic [NUM_LEDS-1:0]                chan_state;
   logic [NUM_LEDS-1:0]                stat_q, stat_d;
   logic [NUM_LEDS-1:0]                led_q, led_d;
   logic [15:0]                        datao_q, datao_d;
   logic [15:0]                        stat_word;
   logic                               addr_ok;
   logic                               force_on;
   logic                               unused_read;

   assign sel          = (di_term_addr == TERM_ADDR);
   assign di_read_rdy  = 1'b1;
   assign di_write_rdy = 1'b1;
   // read data is refreshed every cycle, so the strobe itself needs no action
   assign unused_read  = di_read;

   always_comb begin
      ctrl_d = ctrl_q;
      cfg_d  = cfg_q;
      if (sel && di_write) begin
         if (di_reg_addr == 32'd0) begin
`ifdef LED_BUTTON_OVERRIDE_EN
            ctrl_d = di_reg_datai[2:0];
`else
            ctrl_d = {1'b0, di_reg_datai[1:0]};
`endif
         end
         for (int n = 0; n < NUM_LEDS; n++)
            if (di_reg_addr == 32'(n + 1)) cfg_d[n] = di_reg_datai & CFG_MASK;
      end
   end

   assign div_d = div_q + 1'b1;
   assign pwm_d = pwm_q + 8'd1;

   for (genvar g = 0; g < NUM_LEDS; g++) begin : g_chan
      led_ctrl_chan u_chan (
         .mode    (cfg_q[g][1:0]),
         .rate    (cfg_q[g][4:2]),
         .duty    (cfg_q[g][15:8]),
         .div_top (div_q[DIV_W-1 -: 8]),
         .pwm_cnt (pwm_q),
         .state   (chan_state[g])
      );
   end

`ifdef LED_BUTTON_OVERRIDE_EN
   assign force_on = ctrl_q[2] & ctrl_q[0] & btn_sync_q;
`else
   assign force_on = 1'b0;
`endif

   // STATUS keeps the unforced state; only the pin path sees the override
   assign stat_d = chan_state;
   assign led_d  = chan_state | {NUM_LEDS{force_on}};

   always_comb begin
      stat_word                 = '0;
      stat_word[NUM_LEDS-1:0]   = stat_q;
      stat_word[15]             = btn_sync_q;
      datao_d                   = 16'hAAAA;
      addr_ok                   = 1'b0;
      if (di_reg_addr == 32'd0) begin
         datao_d = {13'd0, ctrl_q};
         addr_ok = 1'b1;
      end
      for (int n = 0; n < NUM_LEDS; n++) begin
         if (di_reg_addr == 32'(n + 1)) begin
            datao_d = cfg_q[n];
            addr_ok = 1'b1;
         end
      end
      if (di_reg_addr == 32'(NUM_LEDS + 1)) begin
         datao_d = stat_word;
         addr_ok = 1'b1;
      end
   end

   assign di_transfer_status = (sel && !addr_ok) ? 16'hFFFF : 16'h0000;
   assign di_reg_datao       = datao_q;
   assign led_b = ctrl_q[0] ? ~(led_q ^ {NUM_LEDS{ctrl_q[1]}}) : {NUM_LEDS{1'b1}};

   always_ff @(posedge ifclk or negedge resetb) begin
      if (!resetb) begin
         ctrl_q     <= '0;
         cfg_q      <= '0;
         div_q      <= '0;
         pwm_q      <= '0;
         btn_meta_q <= 1'b0;
         btn_sync_q <= 1'b0;
         stat_q     <= '0;
         led_q      <= '0;
         datao_q    <= '0;
      end else begin
         ctrl_q     <= ctrl_d;
         cfg_q      <= cfg_d;
         div_q      <= div_d;
         pwm_q      <= pwm_d;
         btn_meta_q <= button;
         btn_sync_q <= btn_meta_q;
         stat_q     <= stat_d;
         led_q      <= led_d;
         datao_q    <= datao_d;
      end
   end
endmodule

// File: tb/tb_led_ctrl_term.sv
// Directed bench for led_ctrl_term (NUM_LEDS=4, DIV_W=8): register table plus LED timing sequences.
module tb_led_ctrl_term;
   localparam int NL = 4;

   logic          ifclk, resetb;
   logic [15:0]   di_term_addr;
   logic [31:0]   di_reg_addr;
   logic          di_write, di_read;
   logic [15:0]   di_reg_datai, di_reg_datao, di_transfer_status;
   logic          di_read_rdy, di_write_rdy;
   logic          button;
   logic [NL-1:0] led_b;

   int n_tests = 0;
   int n_fail  = 0;

   led_ctrl_term #(.NUM_LEDS(NL), .DIV_W(8), .TERM_ADDR(16'h0010)) dut (
      .ifclk(ifclk), .resetb(resetb), .di_term_addr(di_term_addr), .di_reg_addr(di_reg_addr),
      .di_write(di_write), .di_reg_datai(di_reg_datai), .di_read(di_read),
      .di_reg_datao(di_reg_datao), .di_read_rdy(di_read_rdy), .di_write_rdy(di_write_rdy),
      .di_transfer_status(di_transfer_status), .button(button), .led_b(led_b)
   );

   initial ifclk = 1'b0;
   always #5 ifclk = ~ifclk;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp_rd;
      logic [15:0] exp_st;
   } vec_t;
   vec_t vt[15];

`ifdef LED_BUTTON_OVERRIDE_EN
   localparam logic [15:0] CTRL_ALL = 16'h0007;
   localparam logic [15:0] CTRL_5   = 16'h0005;
   localparam logic [3:0]  LED_OVR  = 4'b0000;
`else
   localparam logic [15:0] CTRL_ALL = 16'h0003;
   localparam logic [15:0] CTRL_5   = 16'h0001;
   localparam logic [3:0]  LED_OVR  = 4'b1111;
`endif

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [15:0] d);
      @(negedge ifclk);
      di_term_addr = 16'h0010; di_reg_addr = a; di_reg_datai = d; di_write = 1'b1;
      @(negedge ifclk);
      di_write = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [15:0] d, output logic [15:0] st);
      @(negedge ifclk);
      di_term_addr = 16'h0010; di_reg_addr = a;
      #1 st = di_transfer_status;
      @(negedge ifclk);
      d = di_reg_datao;
      di_read = 1'b1;
      @(negedge ifclk);
      di_read = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge ifclk);
      resetb = 1'b0;
      repeat (2) @(negedge ifclk);
      resetb = 1'b1;
   endtask

   task automatic blink_check(input string nm, input int period, input int cycles);
      int last = -1; int edges = 0; logic prev;
      repeat (3) @(negedge ifclk);
      prev = led_b[1];
      for (int c = 0; c < cycles; c++) begin
         @(negedge ifclk);
         if (led_b[1] !== prev) begin
            if (last >= 0) chk(nm, c - last, period);
            last = c; edges++; prev = led_b[1];
         end
      end
      chk({nm, "_edges"}, 32'(edges >= 3), 1);
   endtask

   task automatic pwm_check(input string nm, input logic [15:0] cfg, input int exp_on);
      int on = 0;
      wr(3, cfg);
      repeat (3) @(negedge ifclk);
      for (int c = 0; c < 256; c++) begin
         @(negedge ifclk);
         if (led_b[2] === 1'b0) on++;
      end
      chk(nm, on, exp_on);
   endtask

   initial begin
      logic [15:0] d, st;
      resetb = 1'b0; di_term_addr = 16'h0010; di_reg_addr = '0; di_write = 1'b0;
      di_reg_datai = '0; di_read = 1'b0; button = 1'b0;

      vt[0]  = '{0, 32'd0,  16'h0000, 16'h0000, 16'h0000};
      vt[1]  = '{0, 32'd1,  16'h0000, 16'h0000, 16'h0000};
      vt[2]  = '{0, 32'd2,  16'h0000, 16'h0000, 16'h0000};
      vt[3]  = '{0, 32'd3,  16'h0000, 16'h0000, 16'h0000};
      vt[4]  = '{0, 32'd4,  16'h0000, 16'h0000, 16'h0000};
      vt[5]  = '{0, 32'd5,  16'h0000, 16'h0000, 16'h0000};
      vt[6]  = '{0, 32'd99, 16'h0000, 16'hAAAA, 16'hFFFF};
      vt[7]  = '{0, 32'h0001_0001, 16'h0000, 16'hAAAA, 16'hFFFF};
      vt[8]  = '{1, 32'd1,  16'hFFFF, 16'hFF1F, 16'h0000};
      vt[9]  = '{1, 32'd2,  16'h1234, 16'h1214, 16'h0000};
      vt[10] = '{1, 32'd1,  16'h0000, 16'h0000, 16'h0000};
      vt[11] = '{1, 32'd99, 16'h5555, 16'hAAAA, 16'hFFFF};
      vt[12] = '{1, 32'd5,  16'hFFFF, 16'h0000, 16'h0000};
      vt[13] = '{1, 32'd0,  16'hFFFF, CTRL_ALL, 16'h0000};
      vt[14] = '{1, 32'd0,  16'h0000, 16'h0000, 16'h0000};

      #1 chk("reset_led_b", led_b, 4'b1111);
      chk("reset_datao", di_reg_datao, 16'h0000);
      repeat (2) @(negedge ifclk);
      resetb = 1'b1;

      for (int i = 0; i < 15; i++) begin
         if (vt[i].wr) wr(vt[i].addr, vt[i].wdata);
         rd(vt[i].addr, d, st);
         chk($sformatf("vec%0d_rd", i), d, vt[i].exp_rd);
         chk($sformatf("vec%0d_st", i), st, vt[i].exp_st);
      end

      // other terminal selected: write ignored, status stays 0
      @(negedge ifclk);
      di_term_addr = 16'h0011; di_reg_addr = 32'd99; di_reg_datai = 16'h0003; di_write = 1'b1;
      #1 chk("unsel_status", di_transfer_status, 16'h0000);
      di_reg_addr = 32'd4;
      @(negedge ifclk);
      di_write = 1'b0;
      rd(4, d, st);
      chk("unsel_write", d, 16'h0000);

      // write and read of the same register in one cycle
      @(negedge ifclk);
      di_term_addr = 16'h0010; di_reg_addr = 32'd2;
      @(negedge ifclk);
      chk("rw_pre", di_reg_datao, 16'h1214);
      di_reg_datai = 16'h00AB; di_write = 1'b1;
      @(negedge ifclk);
      di_write = 1'b0;
      chk("rw_old", di_reg_datao, 16'h1214);
      @(negedge ifclk);
      chk("rw_new", di_reg_datao, 16'h000B);

      do_reset();
      wr(0, 16'h0001);
      chk("en_all_off", led_b, 4'b1111);
      wr(1, 16'h0001);
      chk("on_latency", led_b, 4'b1111);
      @(negedge ifclk);
      chk("on_led0", led_b, 4'b1110);
      wr(0, 16'h0003);
      chk("invert", led_b, 4'b0001);
      wr(0, 16'h0001);
      wr(1, 16'h0000);

      wr(2, 16'h0002);
      blink_check("blink_r0", 128, 600);
      wr(2, 16'h000E);
      blink_check("blink_r3", 16, 100);
      wr(2, 16'h0000);

      pwm_check("pwm_d64", 16'h4003, 64);
      pwm_check("pwm_d0", 16'h0003, 0);
      pwm_check("pwm_d255", 16'hFF03, 255);
      wr(3, 16'h0000);

      // asynchronous reset in the middle of a blink
      wr(2, 16'h000E);
      repeat (5) @(negedge ifclk);
      #2 resetb = 1'b0;
      #1 chk("arst_led_b", led_b, 4'b1111);
      chk("arst_datao", di_reg_datao, 16'h0000);
      @(negedge ifclk);
      resetb = 1'b1;
      rd(2, d, st);
      chk("arst_cfg1", d, 16'h0000);
      rd(0, d, st);
      chk("arst_ctrl", d, 16'h0000);

      // button synchroniser and optional override
      wr(0, 16'h0005);
      rd(0, d, st);
      chk("ctrl_bit2", d, CTRL_5);
      @(negedge ifclk);
      di_reg_addr = 32'd5;
      @(negedge ifclk);
      button = 1'b1;
      repeat (2) @(negedge ifclk);
      chk("btn_sync_2", di_reg_datao, 16'h0000);
      @(negedge ifclk);
      chk("btn_status", di_reg_datao, 16'h8000);
      chk("btn_led_b", led_b, LED_OVR);
      button = 1'b0;
      repeat (2) @(negedge ifclk);
      chk("btn_hold", led_b, LED_OVR);
      @(negedge ifclk);
      chk("btn_release", led_b, 4'b1111);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/led_ctrl_term.md
Name: led_ctrl_term

Overview:
- Parametrised LED controller that sits behind its own device-interface (di_*) terminal in the project top.
- Replaces the fixed single-counter blink and 2-way led_sel mux with NUM_LEDS independent channels.
- Each channel has its own mode (off / on / blink / PWM) and its own rate/duty register, all written from the PC.
- The project top muxes this block's di_reg_datao, di_read_rdy, di_write_rdy and di_transfer_status whenever di_term_addr == TERM_ADDR.

Parameters:
- NUM_LEDS, 4, number of LED channels (1..15).
- DIV_W, 23, width of the shared free-running blink prescaler.
- TERM_ADDR, 16'h0010, di terminal address this block answers on.

Ports:
- ifclk  input  1  48MHz system clock, all logic on rising edge.
- resetb  input  1  asynchronous active-low reset.
- di_term_addr  input  16  selected terminal.
- di_reg_addr  input  32  register address within terminal.
- di_write  input  1  single-cycle write strobe.
- di_reg_datai  input  16  write data.
- di_read  input  1  single-cycle read strobe (data consumed).
- di_reg_datao  output  16  read data.
- di_read_rdy  output  1  read data valid.
- di_write_rdy  output  1  ready to accept write.
- di_transfer_status  output  16  0 = ok, 16'hFFFF = bad register address.
- button  input  1  raw asynchronous push button.
- led_b  output  NUM_LEDS  active-low LED drive.

Behaviour:
- Reset (resetb low, async): all registers cleared, prescaler = 0, PWM counter = 0, button synchroniser = 0, led_b = all 1s (LEDs off), di_reg_datao = 0.
- Register map:
  - Addr 0 CTRL: bit0 global_en, bit1 invert_all; other bits read 0.
  - Addr 1..NUM_LEDS CFG[n-1]: [1:0] mode (0 off, 1 on, 2 blink, 3 pwm), [4:2] rate, [15:8] duty; bits [7:5] read 0.
  - Addr NUM_LEDS+1 STATUS (read-only): [NUM_LEDS-1:0] current LED state (active-high), bit15 synced button.
  - Any other address: writes ignored, reads return 16'hAAAA, di_transfer_status = 16'hFFFF.
- Writes: register updated on the ifclk edge where di_write=1 and di_term_addr==TERM_ADDR. di_write_rdy is constant 1.
- Reads: di_reg_datao registered, updated every cycle from di_reg_addr (one-cycle latency after an address change). di_read_rdy is constant 1. The host holds the address stable at least one cycle before the di_read strobe (di_read needs no other action).
- Status decode is combinational on di_reg_addr. It is 0 when the block is not selected.
- Prescaler: DIV_W-bit counter, increments every cycle, wraps to 0.
- blink_tick[n] = prescaler[DIV_W-1-rate[n]]. rate 0 is slowest, rate 7 is 128x faster.
- PWM: 8-bit counter, increments every cycle, wraps 255->0.
  - LED on while pwm_cnt < duty: duty 0 = always off, duty 255 = on for 255 of 256 cycles.
- LED state pipeline: state computed combinationally, then registered into led_q (one cycle latency from a config write to the pin).
- led_b = ~(led_q ^ {NUM_LEDS{invert_all}}) when global_en=1. When global_en=0, led_b = all 1s.
- Button: 2-flop synchroniser, visible in STATUS two cycles after the input changes.
- Simultaneous write and read to the same register: the read returns the old value that cycle and the new value the next cycle.
- Reset mid-blink: counters restart from 0 and mode registers clear. No glitch beyond the async clear.

Optional Feature:
- Macro: LED_BUTTON_OVERRIDE_EN.
- Defined: CTRL bit2 override_en is implemented. When override_en=1, global_en=1 and the synced button is high, every led_q is forced to 1 regardless of mode. The force is released the cycle after the synced button drops. STATUS still reports the unforced per-channel state.
- Undefined: CTRL bit2 is not implemented, reads 0 and writes are ignored. The button only appears in STATUS bit15.

Test Plan:
- Reset, then read addrs 0..NUM_LEDS+1 -> all return 0 (STATUS bit15 = button level); led_b = 4'b1111; status 0. Read addr 99 -> 16'hAAAA, status 16'hFFFF.
- Write CTRL=1, CFG0=16'h0001 -> led_b[0]=0 two cycles after write, others 1. Then write CTRL=3 -> led_b = 4'b1110 inverted to 4'b0001.
- DIV_W=8, CFG1 mode=2 rate=0 -> led_b[1] toggles every 128 cycles. Rate=3 -> toggles every 16 cycles.
- CFG2 = 16'h4003 (duty 64) -> led on exactly 64 of every 256 cycles. Duty 0 -> never on. Duty 255 -> off 1 of 256.
- Assert resetb low mid-blink for 1 cycle -> led_b goes to all 1s asynchronously, registers read 0 afterwards.
- With LED_BUTTON_OVERRIDE_EN, CTRL=16'h0005, button high -> led_b all 0 within 3 cycles. Button low -> per-mode output restored next cycle. Without the macro, CTRL bit2 reads back 0.
